upc_loop_status_monitor: RTL and testbench
==========================================

// Module: upc_loop_status_monitor
// PURPOSE
//  Synthesizable run-time monitor for one HLS block. It watches the block's ap_ctrl handshake and one pipelined loop inside it.
//  It counts transactions, latency, back-pressure stalls, loop invocations and iterations, and exposes the results as registered counters.
//  It sits beside the DUT top, taps its control signals, and never drives them.
// PARAMETERS
//  STATE_W  1   width of the FSM state vectors (cur_state and the reference states).
//  CNT_W    32  width of every statistics counter.
// PORTS
//  clock              in   1        single clock; all logic on posedge.
//  reset              in   1        synchronous, active-high; clears all state and outputs.
//  finish             in   1        end of simulation/run; sticky freeze request.
//  ap_start           in   1        block handshake: start.
//  ap_ready           in   1        block handshake: ready.
//  ap_done            in   1        block handshake: done.
//  ap_continue        in   1        block handshake: continue (tie 1 if unused).
//  cur_state          in   STATE_W  loop FSM current state.
//  iter_start_state   in   STATE_W  state in which an iteration starts.
//  iter_end_state     in   STATE_W  state in which an iteration ends.
//  quit_state         in   STATE_W  state in which the loop may quit.
//  iter_start_block   in   1        stall for the start state.
//  iter_end_block     in   1        stall for the end state.
//  quit_block         in   1        stall for the quit state.
//  iter_start_enable  in   1        pipeline enable, first stage.
//  iter_end_enable    in   1        pipeline enable, last stage.
//  quit_enable        in   1        pipeline enable for quit.
//  loop_start         in   1        loop handshake: start.
//  loop_done          in   1        loop handshake: done.
//  quit_at_end        in   1        1 = quit requires a same-cycle iter_end event.
//  mod_busy           out  1        block transaction in flight.
//  mod_txn_cnt        out  CNT_W    completed block transactions.
//  mod_last_latency   out  CNT_W    cycles from start accept to ap_done of the last transaction, inclusive.
//  mod_stall_cnt      out  CNT_W    cycles with the block in DONE_WAIT (ap_done=1, ap_continue=0).
//  loop_active        out  1        loop invocation in flight.
//  loop_inv_cnt       out  CNT_W    completed loop invocations.
//  loop_iter_cnt      out  CNT_W    total iter_end events.
//  loop_last_trip     out  CNT_W    iter_end events in the last completed invocation.
//  frozen             out  1        finish has been seen.
// BEHAVIOUR
//  - Reset: all outputs 0; both FSMs in IDLE.
//  - Event terms:
//    - start_ev = cur_state==iter_start_state & iter_start_enable & !iter_start_block
//    - end_ev = same form using the iter_end_* signals.
//    - quit_ev = cur_state==quit_state & quit_enable & !quit_block & (!quit_at_end | end_ev)
//  - Module FSM states: IDLE, BUSY, DONE_WAIT.
//    - IDLE->BUSY on ap_start; the latency counter loads 1.
//    - In BUSY the latency counter increments each cycle.
//    - BUSY on ap_done & ap_continue: mod_last_latency <= counter and mod_txn_cnt += 1.
//      The next state is BUSY with the counter reloaded to 1 if ap_start is high, otherwise IDLE.
//    - BUSY on ap_done & !ap_continue -> DONE_WAIT; latency is captured in that cycle.
//    - DONE_WAIT: mod_stall_cnt += 1 per cycle. On ap_continue -> IDLE and mod_txn_cnt += 1, counted once.
//    - IDLE with ap_start & ap_done in the same cycle: latency 1 and the transaction completes that cycle.
//    - mod_busy = state != IDLE, registered.
//  - Loop FSM states: IDLE, RUN.
//    - IDLE->RUN on loop_start; the trip counter loads 0.
//    - In RUN, each end_ev adds 1 to the trip counter and to loop_iter_cnt.
//    - RUN->IDLE on loop_done or quit_ev: loop_last_trip <= trip count, including an end_ev in that same cycle; loop_inv_cnt += 1.
//    - loop_done and quit_ev together count as one invocation.
//    - start_ev is qualified only; it does not change any counter.
//    - end_ev while in IDLE is ignored.
//    - loop_active = RUN.
//  - All counters saturate at all-ones and never wrap.
//  - finish: when finish=1 at a posedge, frozen <= 1 (sticky).
//    - From that edge on, every counter and status output holds its value.
//    - Only reset clears frozen.
//  - Reset mid-transaction aborts it: nothing is counted and outputs go to 0 on the next edge.
//  - Outputs change 1 cycle after the causing input edge.
// TESTING
//  1. reset=1 for 2 cycles with random inputs -> every output 0.
//  2. ap_start pulse at t0, ap_done at t5, ap_continue=1 -> mod_txn_cnt=1, mod_last_latency=6, mod_busy=0 at t6.
//  3. ap_done at t3 with ap_continue=0 for 3 cycles, then 1 -> mod_stall_cnt=3, mod_txn_cnt=1, mod_last_latency=4.
//  4. loop_start; 10 end_ev cycles plus 2 with iter_end_block=1; loop_done -> loop_last_trip=10, loop_iter_cnt=10, loop_inv_cnt=1.
//  5. finish pulsed while BUSY, then ap_done -> frozen=1, mod_txn_cnt unchanged; reset -> frozen=0.
//  6. CNT_W=4, 20 back-to-back 1-cycle transactions -> mod_txn_cnt=15 (saturated).

Source files
------------

// File: rtl/upc_loop_status_monitor_if.sv
// Control taps from one HLS block: the ap_ctrl handshake plus the loop FSM and pipeline signals.
// The block drives them (master); the status monitor only observes them (slave).
interface upc_loop_status_monitor_if #(
  parameter int unsigned STATE_W = 1
);
  logic               ap_start;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_continue;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] iter_start_state;
  logic [STATE_W-1:0] iter_end_state;
  logic [STATE_W-1:0] quit_state;
  logic               iter_start_block;
  logic               iter_end_block;
  logic               quit_block;
  logic               iter_start_enable;
  logic               iter_end_enable;
  logic               quit_enable;
  logic               loop_start;
  logic               loop_done;
  logic               quit_at_end;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue,
    output cur_state, iter_start_state, iter_end_state, quit_state,
    output iter_start_block, iter_end_block, quit_block,
    output iter_start_enable, iter_end_enable, quit_enable,
    output loop_start, loop_done, quit_at_end
  );

  modport slave (
    input ap_start, ap_ready, ap_done, ap_continue,
    input cur_state, iter_start_state, iter_end_state, quit_state,
    input iter_start_block, iter_end_block, quit_block,
    input iter_start_enable, iter_end_enable, quit_enable,
    input loop_start, loop_done, quit_at_end
  );
endinterface

// File: rtl/upc_loop_status_monitor.sv
// Passive run-time monitor for one HLS block: tracks the ap_ctrl transaction FSM and one
// pipelined loop, and publishes saturating statistics counters that freeze once finish is seen.
module upc_loop_status_monitor #(
  parameter int unsigned STATE_W = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            finish,
  upc_loop_status_monitor_if.slave        tap,
  output logic                            mod_busy,
  output logic [CNT_W-1:0]                mod_txn_cnt,
  output logic [CNT_W-1:0]                mod_last_latency,
  output logic [CNT_W-1:0]                mod_stall_cnt,
  output logic                            loop_active,
  output logic [CNT_W-1:0]                loop_inv_cnt,
  output logic [CNT_W-1:0]                loop_iter_cnt,
  output logic [CNT_W-1:0]                loop_last_trip,
  output logic                            frozen
);

  typedef enum logic [1:0] {
    M_IDLE      = 2'd0,
    M_BUSY      = 2'd1,
    M_DONE_WAIT = 2'd2
  } mod_state_t;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_RUN  = 1'b1
  } loop_state_t;

  mod_state_t         m_state;
  loop_state_t        l_state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [CNT_W-1:0]   lat_nxt;
  logic [CNT_W-1:0]   trip_cnt;
  logic [CNT_W-1:0]   trip_nxt;
  logic [STATE_W-1:0] cur_s;
  logic [STATE_W-1:0] start_s;
  logic [STATE_W-1:0] end_s;
  logic [STATE_W-1:0] quit_s;
  logic               start_ev;
  logic               end_ev;
  logic               quit_ev;
  logic               hold;
  logic               unused_taps;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cur_s   = tap.cur_state;
  assign start_s = tap.iter_start_state;
  assign end_s   = tap.iter_end_state;
  assign quit_s  = tap.quit_state;

  // Pipeline events; start_ev is decoded for completeness but feeds no counter.
  always_comb begin
    start_ev = (cur_s == start_s) && tap.iter_start_enable && !tap.iter_start_block;
    end_ev   = (cur_s == end_s) && tap.iter_end_enable && !tap.iter_end_block;
    quit_ev  = (cur_s == quit_s) && tap.quit_enable && !tap.quit_block &&
               (!tap.quit_at_end || end_ev);
    hold     = finish || frozen;
    lat_nxt  = sat_inc(lat_cnt);
    trip_nxt = end_ev ? sat_inc(trip_cnt) : trip_cnt;
  end

  assign unused_taps = &{1'b0, tap.ap_ready, start_ev};

  // Block transaction FSM: latency, completions and DONE_WAIT back-pressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_state          <= M_IDLE;
      lat_cnt          <= '0;
      mod_busy         <= 1'b0;
      mod_txn_cnt      <= '0;
      mod_last_latency <= '0;
      mod_stall_cnt    <= '0;
      frozen           <= 1'b0;
    end else if (hold) begin
      frozen <= 1'b1;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (tap.ap_start) begin
            if (tap.ap_done) begin
              // Start and done together: a one-cycle transaction.
              mod_last_latency <= CNT_W'(1);
              if (tap.ap_continue) begin
                mod_txn_cnt <= sat_inc(mod_txn_cnt);
              end else begin
                m_state  <= M_DONE_WAIT;
                mod_busy <= 1'b1;
              end
            end else begin
              m_state  <= M_BUSY;
              mod_busy <= 1'b1;
              lat_cnt  <= CNT_W'(1);
            end
          end
        end
        M_BUSY: begin
          if (tap.ap_done) begin
            mod_last_latency <= lat_nxt;
            if (tap.ap_continue) begin
              mod_txn_cnt <= sat_inc(mod_txn_cnt);
              if (tap.ap_start) begin
                lat_cnt <= CNT_W'(1);
              end else begin
                m_state  <= M_IDLE;
                mod_busy <= 1'b0;
              end
            end else begin
              m_state <= M_DONE_WAIT;
            end
          end else begin
            lat_cnt <= lat_nxt;
          end
        end
        M_DONE_WAIT: begin
          mod_stall_cnt <= sat_inc(mod_stall_cnt);
          if (tap.ap_continue) begin
            mod_txn_cnt <= sat_inc(mod_txn_cnt);
            m_state     <= M_IDLE;
            mod_busy    <= 1'b0;
          end
        end
        default: begin
          m_state  <= M_IDLE;
          mod_busy <= 1'b0;
        end
      endcase
    end
  end

  // Loop invocation FSM: per-invocation trip count and running iteration total.
  always_ff @(posedge clock) begin
    if (reset) begin
      l_state        <= L_IDLE;
      trip_cnt       <= '0;
      loop_active    <= 1'b0;
      loop_inv_cnt   <= '0;
      loop_iter_cnt  <= '0;
      loop_last_trip <= '0;
    end else if (!hold) begin
      case (l_state)
        L_IDLE: begin
          if (tap.loop_start) begin
            l_state     <= L_RUN;
            loop_active <= 1'b1;
            trip_cnt    <= '0;
          end
        end
        L_RUN: begin
          if (end_ev) begin
            loop_iter_cnt <= sat_inc(loop_iter_cnt);
          end
          // A same-cycle end_ev still belongs to the invocation that is closing.
          if (tap.loop_done || quit_ev) begin
            loop_last_trip <= trip_nxt;
            loop_inv_cnt   <= sat_inc(loop_inv_cnt);
            l_state        <= L_IDLE;
            loop_active    <= 1'b0;
          end else begin
            trip_cnt <= trip_nxt;
          end
        end
        default: begin
          l_state     <= L_IDLE;
          loop_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upc_loop_status_monitor.sv
// Randomized self-checking bench for upc_loop_status_monitor; expectations come from a
// transaction/invocation-level model kept in the bench, with a 4-bit instance for saturation.
module tb_upc_loop_status_monitor;
  localparam int unsigned STATE_W = 1;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SAT_W   = 4;

  logic clock = 1'b0;
  logic reset;
  logic finish;

  upc_loop_status_monitor_if #(.STATE_W(STATE_W)) bus ();

  logic             busy, active, frz;
  logic [CNT_W-1:0] txn, lat, stall, inv, iter, trip;
  logic             s_busy, s_active, s_frz;
  logic [SAT_W-1:0] s_txn, s_lat, s_stall, s_inv, s_iter, s_trip;

  upc_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .finish(finish), .tap(bus),
    .mod_busy(busy), .mod_txn_cnt(txn), .mod_last_latency(lat), .mod_stall_cnt(stall),
    .loop_active(active), .loop_inv_cnt(inv), .loop_iter_cnt(iter), .loop_last_trip(trip),
    .frozen(frz)
  );

  upc_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(SAT_W)) dut_sat (
    .clock(clock), .reset(reset), .finish(finish), .tap(bus),
    .mod_busy(s_busy), .mod_txn_cnt(s_txn), .mod_last_latency(s_lat), .mod_stall_cnt(s_stall),
    .loop_active(s_active), .loop_inv_cnt(s_inv), .loop_iter_cnt(s_iter), .loop_last_trip(s_trip),
    .frozen(s_frz)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference model: running totals at transaction / invocation granularity.
  int unsigned e_txn, e_lat, e_stall, e_inv, e_iter, e_trip;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    e_txn = 0; e_lat = 0; e_stall = 0; e_inv = 0; e_iter = 0; e_trip = 0;
  endtask

  task automatic set_idle();
    finish                = 1'b0;
    bus.ap_start          = 1'b0;
    bus.ap_ready          = 1'b0;
    bus.ap_done           = 1'b0;
    bus.ap_continue       = 1'b1;
    bus.cur_state         = '0;
    bus.iter_start_state  = '0;
    bus.iter_end_state    = '0;
    bus.quit_state        = '0;
    bus.iter_start_block  = 1'b0;
    bus.iter_end_block    = 1'b0;
    bus.quit_block        = 1'b0;
    bus.iter_start_enable = 1'b0;
    bus.iter_end_enable   = 1'b0;
    bus.quit_enable       = 1'b0;
    bus.loop_start        = 1'b0;
    bus.loop_done         = 1'b0;
    bus.quit_at_end       = 1'b0;
  endtask

  task automatic randomize_all();
    logic [17:0] r;
    r = 18'($urandom);
    {finish, bus.ap_start, bus.ap_ready, bus.ap_done, bus.ap_continue,
     bus.cur_state, bus.iter_start_state, bus.iter_end_state, bus.quit_state,
     bus.iter_start_block, bus.iter_end_block, bus.quit_block,
     bus.iter_start_enable, bus.iter_end_enable, bus.quit_enable,
     bus.loop_start, bus.loop_done, bus.quit_at_end} = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    randomize_all();
    tick();
    randomize_all();
    tick();
    checks++; if ({busy, active, frz} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {busy, active, frz}); else passed++;
    checks++; if ({txn, lat, stall} !== '0)
      $display("FAIL reset_mod_cnt: got %0d/%0d/%0d want 0/0/0", txn, lat, stall); else passed++;
    checks++; if ({inv, iter, trip} !== '0)
      $display("FAIL reset_loop_cnt: got %0d/%0d/%0d want 0/0/0", inv, iter, trip); else passed++;
    checks++; if ({s_busy, s_active, s_frz, s_txn, s_lat, s_stall, s_inv, s_iter, s_trip} !== '0)
      $display("FAIL reset_sat_inst: got nonzero output want all 0"); else passed++;
    set_idle();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single_txn();
    bus.ap_start = 1'b1; tick();
    bus.ap_start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    repeat (4) tick();
    bus.ap_done = 1'b1; tick();
    bus.ap_done = 1'b0;
    e_txn++; e_lat = 6;
    checks++; if (txn !== e_txn) $display("FAIL single_txn: got %0d want %0d", txn, e_txn); else passed++;
    checks++; if (lat !== e_lat) $display("FAIL single_lat: got %0d want %0d", lat, e_lat); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_done_wait();
    bus.ap_start = 1'b1; tick();
    bus.ap_start = 1'b0;
    repeat (2) tick();
    bus.ap_done = 1'b1; bus.ap_continue = 1'b0;
    repeat (3) tick();
    checks++; if (txn !== e_txn) $display("FAIL wait_no_txn: got %0d want %0d", txn, e_txn); else passed++;
    bus.ap_continue = 1'b1; tick();
    bus.ap_done = 1'b0;
    e_txn++; e_lat = 4; e_stall += 3;
    checks++; if (stall !== e_stall) $display("FAIL wait_stall: got %0d want %0d", stall, e_stall); else passed++;
    checks++; if (txn !== e_txn) $display("FAIL wait_txn: got %0d want %0d", txn, e_txn); else passed++;
    checks++; if (lat !== e_lat) $display("FAIL wait_lat: got %0d want %0d", lat, e_lat); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL wait_idle: got %b want 0", busy); else passed++;
  endtask

  // Second start accepted in the done cycle of the first: cycles 0..2 then 2..5.
  task automatic test_back_to_back();
    bus.ap_start = 1'b1; tick();
    bus.ap_start = 1'b0; tick();
    bus.ap_start = 1'b1; bus.ap_done = 1'b1; tick();
    bus.ap_start = 1'b0; bus.ap_done = 1'b0;
    e_txn++; e_lat = 3;
    checks++; if (lat !== e_lat) $display("FAIL b2b_lat1: got %0d want %0d", lat, e_lat); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
    repeat (2) tick();
    bus.ap_done = 1'b1; tick();
    bus.ap_done = 1'b0;
    e_txn++; e_lat = 4;
    checks++; if (lat !== e_lat) $display("FAIL b2b_lat2: got %0d want %0d", lat, e_lat); else passed++;
    checks++; if (txn !== e_txn) $display("FAIL b2b_txn: got %0d want %0d", txn, e_txn); else passed++;
  endtask

  task automatic test_random_txn();
    int unsigned l, s, g;
    for (int n = 0; n < 8; n++) begin
      l = $urandom_range(1, 8);
      s = $urandom_range(0, 3);
      g = $urandom_range(0, 2);
      for (int i = 0; i < int'(g); i++) begin
        bus.ap_continue = 1'($urandom); bus.ap_ready = 1'($urandom); tick();
      end
      bus.ap_start = 1'b1;
      bus.ap_done = (l == 1);
      bus.ap_continue = (l == 1) ? (s == 0) : 1'($urandom);
      tick();
      bus.ap_start = 1'b0;
      if (l > 1) begin
        bus.ap_done = 1'b0;
        for (int i = 0; i < int'(l) - 2; i++) begin
          bus.ap_continue = 1'($urandom); tick();
        end
        bus.ap_done = 1'b1; bus.ap_continue = (s == 0); tick();
      end
      if (s > 0) begin
        for (int i = 0; i < int'(s) - 1; i++) tick();
        bus.ap_continue = 1'b1; tick();
      end
      bus.ap_done = 1'b0; bus.ap_continue = 1'b1;
      e_txn++; e_lat = l; e_stall += s;
      checks++; if (txn !== e_txn) $display("FAIL rnd_txn[%0d]: got %0d want %0d", n, txn, e_txn); else passed++;
      checks++; if (lat !== e_lat) $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, e_lat); else passed++;
      checks++; if (stall !== e_stall) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, stall, e_stall); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rnd_idle[%0d]: got %b want 0", n, busy); else passed++;
    end
  endtask

  task automatic test_loop();
    bus.cur_state = 1'b1; bus.iter_end_state = 1'b1; bus.iter_end_enable = 1'b1;
    repeat (3) tick();
    checks++; if (iter !== e_iter) $display("FAIL loop_idle_ignored: got %0d want %0d", iter, e_iter); else passed++;
    bus.loop_start = 1'b1; tick();
    bus.loop_start = 1'b0;
    checks++; if (active !== 1'b1) $display("FAIL loop_active: got %b want 1", active); else passed++;
    for (int i = 0; i < 12; i++) begin
      bus.iter_end_block = (i == 3 || i == 8);
      tick();
    end
    bus.iter_end_block = 1'b0; bus.iter_end_enable = 1'b0;
    bus.loop_done = 1'b1; tick();
    bus.loop_done = 1'b0;
    e_iter += 10; e_trip = 10; e_inv++;
    checks++; if (trip !== e_trip) $display("FAIL loop_trip: got %0d want %0d", trip, e_trip); else passed++;
    checks++; if (iter !== e_iter) $display("FAIL loop_iter: got %0d want %0d", iter, e_iter); else passed++;
    checks++; if (inv !== e_inv) $display("FAIL loop_inv: got %0d want %0d", inv, e_inv); else passed++;
    checks++; if (active !== 1'b0) $display("FAIL loop_inactive: got %b want 0", active); else passed++;
    set_idle();
  endtask

  task automatic test_random_loop();
    int unsigned k, mode, cnt;
    logic ev, qev;
    for (int n = 0; n < 8; n++) begin
      bus.loop_start = 1'b1;
      bus.iter_end_enable = 1'($urandom); bus.cur_state = 1'($urandom);
      tick();
      bus.loop_start = 1'b0;
      cnt = 0;
      k = $urandom_range(2, 12);
      for (int i = 0; i < int'(k); i++) begin
        {bus.cur_state, bus.iter_end_state, bus.iter_end_enable, bus.iter_end_block,
         bus.iter_start_state, bus.iter_start_enable, bus.iter_start_block} = 7'($urandom);
        ev = (bus.cur_state == bus.iter_end_state) && bus.iter_end_enable && !bus.iter_end_block;
        if (ev) cnt++;
        tick();
      end
      mode = $urandom_range(0, 2);
      {bus.cur_state, bus.iter_end_state, bus.iter_end_enable, bus.iter_end_block} = 4'($urandom);
      bus.loop_done = (mode != 1);
      if (mode != 0) begin
        bus.quit_state = bus.cur_state; bus.quit_enable = 1'b1; bus.quit_block = 1'b0;
        bus.quit_at_end = 1'($urandom);
        if (mode == 1 && bus.quit_at_end) begin
          bus.iter_end_state = bus.cur_state; bus.iter_end_enable = 1'b1; bus.iter_end_block = 1'b0;
        end
      end
      ev  = (bus.cur_state == bus.iter_end_state) && bus.iter_end_enable && !bus.iter_end_block;
      qev = (bus.cur_state == bus.quit_state) && bus.quit_enable && !bus.quit_block &&
            (!bus.quit_at_end || ev);
      if (ev) cnt++;
      tick();
      set_idle();
      e_iter += cnt; e_trip = cnt; e_inv++;
      checks++; if (!(bus.loop_done || qev) && mode == 1) $display("FAIL rnd_loop_stim[%0d]: quit not formed", n);
      else passed++;
      checks++; if (trip !== e_trip) $display("FAIL rnd_trip[%0d]: got %0d want %0d", n, trip, e_trip); else passed++;
      checks++; if (iter !== e_iter) $display("FAIL rnd_iter[%0d]: got %0d want %0d", n, iter, e_iter); else passed++;
      checks++; if (inv !== e_inv) $display("FAIL rnd_inv[%0d]: got %0d want %0d", n, inv, e_inv); else passed++;
      checks++; if (active !== 1'b0) $display("FAIL rnd_active[%0d]: got %b want 0", n, active); else passed++;
    end
  endtask

  task automatic test_freeze();
    bus.ap_start = 1'b1; tick();
    bus.ap_start = 1'b0; tick();
    finish = 1'b1; tick();
    finish = 1'b0;
    bus.ap_done = 1'b1; tick();
    bus.ap_done = 1'b0;
    bus.loop_start = 1'b1; tick();
    bus.loop_start = 1'b0;
    bus.cur_state = 1'b0; bus.iter_end_state = 1'b0; bus.iter_end_enable = 1'b1;
    repeat (3) tick();
    bus.iter_end_enable = 1'b0;
    checks++; if (frz !== 1'b1) $display("FAIL frz_set: got %b want 1", frz); else passed++;
    checks++; if (txn !== e_txn) $display("FAIL frz_txn: got %0d want %0d", txn, e_txn); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL frz_busy_held: got %b want 1", busy); else passed++;
    checks++; if ({active, iter} !== {1'b0, CNT_W'(e_iter)})
      $display("FAIL frz_loop: got %b/%0d want 0/%0d", active, iter, e_iter); else passed++;
    reset = 1'b1; tick();
    reset = 1'b0;
    model_clear();
    checks++; if (frz !== 1'b0) $display("FAIL frz_clear: got %b want 0", frz); else passed++;
    checks++; if ({busy, txn} !== '0) $display("FAIL frz_reset_mod: got %b/%0d want 0/0", busy, txn); else passed++;
    // Reset in the middle of a transaction: nothing is counted.
    bus.ap_start = 1'b1; tick();
    bus.ap_start = 1'b0; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    bus.ap_done = 1'b1; tick();
    bus.ap_done = 1'b0;
    checks++; if ({txn, lat} !== '0) $display("FAIL abort_txn: got %0d/%0d want 0/0", txn, lat); else passed++;
  endtask

  task automatic test_saturation();
    reset = 1'b1; tick();
    reset = 1'b0;
    model_clear();
    bus.ap_start = 1'b1; bus.ap_done = 1'b1; bus.ap_continue = 1'b1;
    repeat (20) tick();
    bus.ap_start = 1'b0; bus.ap_done = 1'b0;
    checks++; if (s_txn !== 4'd15) $display("FAIL sat_txn: got %0d want 15", s_txn); else passed++;
    checks++; if (txn !== 20) $display("FAIL wide_txn: got %0d want 20", txn); else passed++;
    checks++; if (s_lat !== 4'd1) $display("FAIL sat_lat: got %0d want 1", s_lat); else passed++;
    checks++; if (s_busy !== 1'b0) $display("FAIL sat_busy: got %b want 0", s_busy); else passed++;
    bus.loop_start = 1'b1; tick();
    bus.loop_start = 1'b0;
    bus.cur_state = 1'b1; bus.iter_end_state = 1'b1; bus.iter_end_enable = 1'b1;
    repeat (20) tick();
    bus.iter_end_enable = 1'b0; bus.loop_done = 1'b1; tick();
    bus.loop_done = 1'b0;
    checks++; if ({s_iter, s_trip} !== 8'hFF) $display("FAIL sat_loop: got %0d/%0d want 15/15", s_iter, s_trip); else passed++;
    checks++; if ({iter, trip} !== {CNT_W'(20), CNT_W'(20)})
      $display("FAIL wide_loop: got %0d/%0d want 20/20", iter, trip); else passed++;
    checks++; if (s_inv !== 4'd1) $display("FAIL sat_inv: got %0d want 1", s_inv); else passed++;
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    model_clear();
    test_reset();
    test_single_txn();
    test_done_wait();
    test_back_to_back();
    test_random_txn();
    test_loop();
    test_random_loop();
    test_freeze();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
